// File: rtl/radix_counter_pkg.sv
// Shared constants for the cascaded radix counter: default geometry and terminal-count modes.
// Pure definitions; no logic, no latency, no flow control.
package radix_counter_pkg;

    localparam int DEF_RADIX     = 10;
    localparam int DEF_DIGITS    = 4;

    localparam int WRAP_MODE     = 1;
    localparam int SATURATE_MODE = 0;

endpackage

// File: rtl/radix_counter_digit.sv
// One mod-RADIX up/down digit with clear, clamped parallel load and step (carry-in) control.
// One-edge latency from command to dig; never stalls, no backpressure.
module radix_digit
    import radix_counter_pkg::*;
#(
    parameter int RADIX = DEF_RADIX,
    parameter int W     = $clog2(RADIX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         up,
    input  logic         step,
    input  logic [W-1:0] load_dig,
    output logic [W-1:0] dig,
    output logic         at_term,
    output logic         over
);

    localparam logic [W-1:0] MAX = W'(RADIX - 1);
    localparam logic [W:0]   RAD = (W + 1)'(RADIX);

    assign over    = ({1'b0, load_dig} >= RAD);
    assign at_term = up ? (dig == MAX) : (dig == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig <= '0;
        end else if (clr) begin
            dig <= '0;
        end else if (load) begin
            // Out-of-range load digits clamp to the largest legal value.
            dig <= over ? MAX : load_dig;
        end else if (step) begin
            if (up) begin
                dig <= (dig == MAX) ? '0 : dig + W'(1);
            end else begin
                dig <= (dig == '0) ? MAX : dig - W'(1);
            end
        end
    end

endmodule

// File: rtl/radix_counter.sv
// Cascaded DIGITS x mod-RADIX up/down counter with clear/load, wrap or saturate at terminal count.
// Count, wrapped and load_err update one edge after the command; tc is combinational; no backpressure.
module radix_counter
    import radix_counter_pkg::*;
#(
    parameter int RADIX  = DEF_RADIX,
    parameter int DIGITS = DEF_DIGITS,
    parameter int WRAP   = WRAP_MODE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             up,
    input  logic                             clr,
    input  logic                             load,
    input  logic [DIGITS*$clog2(RADIX)-1:0]  load_val,
    output logic [DIGITS*$clog2(RADIX)-1:0]  count,
    output logic                             tc,
    output logic                             wrapped,
    output logic                             load_err
);

    localparam int   W       = $clog2(RADIX);
    localparam logic WRAP_EN = (WRAP == WRAP_MODE);

    logic [DIGITS:0]   cin;
    logic [DIGITS-1:0] at_term;
    logic [DIGITS-1:0] over;
    logic              terminal;
    logic              advance;

    // Digit i steps only when every lower digit sits at its terminal value.
    always_comb begin
        cin    = '0;
        cin[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            cin[i+1] = cin[i] & at_term[i];
        end
    end

    assign terminal = cin[DIGITS];
    assign advance  = en & (~terminal | WRAP_EN);
    assign tc       = en & terminal & ~clr & ~load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        radix_digit #(
            .RADIX (RADIX),
            .W     (W)
        ) u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .load     (load),
            .up       (up),
            .step     (advance & cin[i]),
            .load_dig (load_val[i*W +: W]),
            .dig      (count[i*W +: W]),
            .at_term  (at_term[i]),
            .over     (over[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrapped  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrapped  <= ~clr & ~load & en & terminal & WRAP_EN;
            load_err <= ~clr & load & (|over);
        end
    end

endmodule

// File: tb/tb_radix_counter.sv
// Randomized and directed bench for radix_counter against an integer-valued reference model.
module tb_radix_counter;

    logic        clk;
    logic        rst_n;
    logic        en, up, clr, load;
    logic [15:0] lv10;
    logic [5:0]  lv6;

    logic [15:0] count10, countS;
    logic [5:0]  count6;
    logic        tc10, tcS, tc6;
    logic        wr10, wrS, wr6;
    logic        le10, leS, le6;

    int m10, mS, m6;
    bit ew10, ewS, ew6, el10, elS, el6;
    bit etc10, etcS, etc6;
    logic stc10, stcS, stc6;
    int checks, passes;

    radix_counter #(.RADIX(10), .DIGITS(4), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv10), .count(count10), .tc(tc10), .wrapped(wr10), .load_err(le10));

    radix_counter #(.RADIX(10), .DIGITS(4), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv10), .count(countS), .tc(tcS), .wrapped(wrS), .load_err(leS));

    radix_counter #(.RADIX(6), .DIGITS(2), .WRAP(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv6), .count(count6), .tc(tc6), .wrapped(wr6), .load_err(le6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the count is a plain integer in [0, R^D); digits exist only at the packing boundary.
    function automatic void mdl(input int R, input int D, input int W, input bit wrapm,
                                input int v, input logic [15:0] lv,
                                output int nv, output bit nwr, output bit nle, output bit tcx);
        int  maxv;
        int  d;
        bit  term;
        maxv = 1;
        for (int i = 0; i < D; i++) maxv = maxv * R;
        term = up ? (v == maxv - 1) : (v == 0);
        tcx  = en && term && !clr && !load;
        nv   = v;
        nwr  = 1'b0;
        nle  = 1'b0;
        if (clr) begin
            nv = 0;
        end else if (load) begin
            nv = 0;
            for (int i = D - 1; i >= 0; i--) begin
                d = int'((lv >> (i * W)) & ((16'd1 << W) - 16'd1));
                if (d >= R) begin
                    d   = R - 1;
                    nle = 1'b1;
                end
                nv = nv * R + d;
            end
        end else if (en) begin
            if (term && !wrapm) begin
                nv = v;
            end else begin
                nv  = up ? (v + 1) % maxv : (v + maxv - 1) % maxv;
                nwr = term;
            end
        end
    endfunction

    function automatic logic [15:0] enc(input int v, input int R, input int D, input int W);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r = r | (16'(x % R) << (i * W));
            x = x / R;
        end
        return r;
    endfunction

    task automatic advance();
        int n10, nS, n6;
        bit w10, wS, w6, l10, lS, l6;
        #2;
        stc10 = tc10; stcS = tcS; stc6 = tc6;
        mdl(10, 4, 4, 1'b1, m10, lv10, n10, w10, l10, etc10);
        mdl(10, 4, 4, 1'b0, mS, lv10, nS, wS, lS, etcS);
        mdl(6, 2, 3, 1'b1, m6, {10'b0, lv6}, n6, w6, l6, etc6);
        @(posedge clk); #1;
        m10 = n10; ew10 = w10; el10 = l10;
        mS  = nS;  ewS  = wS;  elS  = lS;
        m6  = n6;  ew6  = w6;  el6  = l6;
    endtask

    task automatic model_reset();
        m10 = 0; mS = 0; m6 = 0;
        ew10 = 0; ewS = 0; ew6 = 0;
        el10 = 0; elS = 0; el6 = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0;
        lv10 = '0; lv6 = '0;
        model_reset();
        #12;
        checks++; if (count10 !== 16'h0000) $display("FAIL reset_count got %h want 0000", count10); else passes++;
        checks++; if ({wr10, le10} !== 2'b00) $display("FAIL reset_flags got %b want 00", {wr10, le10}); else passes++;
        @(posedge clk); #1;
        checks++; if (count6 !== 6'o00) $display("FAIL reset_hold6 got %o want 00", count6); else passes++;
        checks++; if (countS !== 16'h0000) $display("FAIL reset_holdS got %h want 0000", countS); else passes++;
        rst_n = 1'b1; en = 1'b0;
    endtask

    task automatic test_rollover();
        load = 1'b1; lv10 = 16'h0999; lv6 = 6'o45; en = 1'b0;
        advance();
        checks++; if (count10 !== 16'h0999) $display("FAIL load0999 got %h want 0999", count10); else passes++;
        load = 1'b0; en = 1'b1; up = 1'b1;
        advance();
        checks++; if (count10 !== 16'h1000) $display("FAIL rollover got %h want 1000", count10); else passes++;
        checks++; if (wr10 !== 1'b0) $display("FAIL rollover_wrapped got %b want 0", wr10); else passes++;
        checks++; if (count6 !== 6'o50) $display("FAIL rollover6 got %o want 50", count6); else passes++;
    endtask

    task automatic test_wrap();
        load = 1'b1; en = 1'b0; lv10 = 16'h9999; lv6 = 6'o55;
        advance();
        load = 1'b0; en = 1'b1; up = 1'b1;
        advance();
        checks++; if (stc10 !== 1'b1) $display("FAIL wrap_tc got %b want 1", stc10); else passes++;
        checks++; if (count10 !== 16'h0000) $display("FAIL wrap_count got %h want 0000", count10); else passes++;
        checks++; if (wr10 !== 1'b1) $display("FAIL wrap_wrapped got %b want 1", wr10); else passes++;
        checks++; if ({count6, wr6} !== {6'o00, 1'b1}) $display("FAIL wrap6 got %o/%b want 00/1", count6, wr6); else passes++;
        checks++; if ({countS, wrS, stcS} !== {16'h9999, 1'b0, 1'b1}) $display("FAIL sat_up got %h/%b/%b want 9999/0/1", countS, wrS, stcS); else passes++;
        en = 1'b0;
        advance();
        checks++; if (wr10 !== 1'b0) $display("FAIL wrap_one_cycle got %b want 0", wr10); else passes++;
    endtask

    task automatic test_saturate();
        clr = 1'b1;
        advance();
        clr = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++; if (countS !== 16'h0000) $display("FAIL sat_count[%0d] got %h want 0000", i, countS); else passes++;
            checks++; if ({stcS, wrS} !== 2'b10) $display("FAIL sat_tc_wr[%0d] got %b want 10", i, {stcS, wrS}); else passes++;
            if (i == 0) begin
                checks++; if (count6 !== 6'o55) $display("FAIL down6 got %o want 55", count6); else passes++;
            end
        end
    endtask

    task automatic test_priority();
        clr = 1'b1; load = 1'b1; en = 1'b1; lv10 = 16'h9999; lv6 = 6'o44;
        advance();
        checks++; if ({count10, le10} !== {16'h0000, 1'b0}) $display("FAIL prio_clr got %h/%b want 0000/0", count10, le10); else passes++;
        clr = 1'b0; lv10 = {4'd7, 4'd5, 4'd12, 4'd3}; lv6 = {3'd7, 3'd2};
        advance();
        checks++; if (count10 !== 16'h7593) $display("FAIL clamp got %h want 7593", count10); else passes++;
        checks++; if (le10 !== 1'b1) $display("FAIL load_err got %b want 1", le10); else passes++;
        checks++; if ({count6, le6} !== {6'o52, 1'b1}) $display("FAIL clamp6 got %o/%b want 52/1", count6, le6); else passes++;
        load = 1'b0; en = 1'b0;
        advance();
        checks++; if (le10 !== 1'b0) $display("FAIL load_err_one_cycle got %b want 0", le10); else passes++;
    endtask

    task automatic test_async_reset();
        load = 1'b1; en = 1'b0; lv10 = 16'h0457; lv6 = 6'o21;
        advance();
        load = 1'b0; en = 1'b1; up = 1'b1;
        #3; rst_n = 1'b0;
        #1;
        checks++; if (count10 !== 16'h0000) $display("FAIL async_count got %h want 0000", count10); else passes++;
        checks++; if (count6 !== 6'o00) $display("FAIL async_count6 got %o want 00", count6); else passes++;
        model_reset();
        #1; rst_n = 1'b1;
        advance();
        checks++; if (count10 !== 16'h0001) $display("FAIL post_reset got %h want 0001", count10); else passes++;
        checks++; if (count6 !== 6'o01) $display("FAIL post_reset6 got %o want 01", count6); else passes++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clr  = ($urandom_range(0, 9) == 0);
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) != 0;
            lv10 = 16'($urandom);
            lv6  = 6'($urandom);
            advance();
            checks++; if (count10 !== enc(m10, 10, 4, 4)) $display("FAIL rnd_count10[%0d] got %h want %h", n, count10, enc(m10, 10, 4, 4)); else passes++;
            checks++; if (countS !== enc(mS, 10, 4, 4)) $display("FAIL rnd_countS[%0d] got %h want %h", n, countS, enc(mS, 10, 4, 4)); else passes++;
            checks++; if ({10'b0, count6} !== enc(m6, 6, 2, 3)) $display("FAIL rnd_count6[%0d] got %o want %o", n, count6, enc(m6, 6, 2, 3)); else passes++;
            checks++; if ({wr10, wrS, wr6} !== {ew10, ewS, ew6}) $display("FAIL rnd_wrapped[%0d] got %b want %b", n, {wr10, wrS, wr6}, {ew10, ewS, ew6}); else passes++;
            checks++; if ({le10, leS, le6} !== {el10, elS, el6}) $display("FAIL rnd_load_err[%0d] got %b want %b", n, {le10, leS, le6}, {el10, elS, el6}); else passes++;
            checks++; if ({stc10, stcS, stc6} !== {etc10, etcS, etc6}) $display("FAIL rnd_tc[%0d] got %b want %b", n, {stc10, stcS, stc6}, {etc10, etcS, etc6}); else passes++;
            for (int d = 0; d < 2; d++) begin
                checks++; if (count6[d*3 +: 3] >= 3'd6) $display("FAIL rnd_range6[%0d] digit %0d got %0d want <6", n, d, count6[d*3 +: 3]); else passes++;
            end
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_rollover();
        test_wrap();
        test_saturate();
        test_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
